// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I control sequencer with memory handshake and timeout fault
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT  = 15,
   parameter int ENABLE_JAL   = 1,
   parameter int TRAP_ILLEGAL = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic       illegal_op,
   output logic       fault
);
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(MEM_TIMEOUT);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, FAULT
   } state_t;

   state_t state, state_next;
   logic [CW-1:0] wait_cnt;
   logic pc_update, branch, mem_write, ir_write, reg_write, illegal, in_fault;
   logic mem_state, timeout;

   assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign timeout   = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LIMIT) && !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            wait_cnt <= '0;
         else if (mem_state && !mem_ready && wait_cnt != CNT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 3'b000;
      ALUOp      = 2'b00;
      pc_update  = 1'b0;
      branch     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      in_fault   = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_write  = mem_ready;
            pc_update = mem_ready;
            if (mem_ready)    state_next = DECODE;
            else if (timeout) state_next = FAULT;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            if (op == OP_BEQ)      ImmSrc = 3'b010;
            else if (op == OP_JAL) ImmSrc = 3'b011;
            if (op == OP_LW || op == OP_SW)            state_next = MEMADR;
            else if (op == OP_R)                       state_next = EXECUTER;
            else if (op == OP_I)                       state_next = EXECUTEI;
            else if (op == OP_BEQ)                     state_next = BEQ;
            else if (op == OP_JAL && ENABLE_JAL != 0)  state_next = JAL;
            else begin
               illegal    = 1'b1;
               state_next = (TRAP_ILLEGAL != 0) ? FAULT : FETCH;
            end
         end
         MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ImmSrc     = (op == OP_SW) ? 3'b001 : 3'b000;
            state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready)    state_next = MEMWB;
            else if (timeout) state_next = FAULT;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         // Strobe held every cycle until the memory accepts the write.
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready)    state_next = FETCH;
            else if (timeout) state_next = FAULT;
         end
         EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUOp      = 2'b10;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUOp      = 2'b10;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            ALUSrcA    = 2'b10;
            ALUOp      = 2'b01;
            branch     = 1'b1;
            state_next = FETCH;
         end
         JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         FAULT:   in_fault = 1'b1;
         default: state_next = FAULT;
      endcase
   end

   // Strobes are forced low while reset is held so nothing completes after rst_n falls.
   assign PCWrite    = rst_n & (pc_update | (branch & Zero));
   assign IRWrite    = rst_n & ir_write;
   assign MemWrite   = rst_n & mem_write;
   assign RegWrite   = rst_n & reg_write;
   assign illegal_op = rst_n & illegal;
   assign fault      = rst_n & in_fault;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench against an instruction-sequence model
module tb_multicycle_control_fsm;
   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
   localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
   localparam int TMO[2] = '{15, 3};
   localparam int TRAP[2] = '{1, 0};
   localparam int JEN[2] = '{1, 0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic zero = 1'b0;
   logic [6:0] op_in[2];
   logic mr_in[2];
   logic pcw0, adr0, mw0, irw0, rw0, ill0, flt0, pcw1, adr1, mw1, irw1, rw1, ill1, flt1;
   logic [1:0] rs0, a0, b0, aop0, rs1, a1, b1, aop1;
   logic [2:0] imm0, imm1;
   logic [17:0] out0, out1, exp0, exp1;
   int checks = 0, failures = 0;

   string seq[2][8];
   int slen[2], sidx[2], wcnt[2];

   always #5 clk = ~clk;

   multicycle_control_fsm #(.MEM_TIMEOUT(15), .ENABLE_JAL(1), .TRAP_ILLEGAL(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op_in[0]), .Zero(zero), .mem_ready(mr_in[0]),
      .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0),
      .ALUSrcA(a0), .ALUSrcB(b0), .ImmSrc(imm0), .ALUOp(aop0), .RegWrite(rw0),
      .illegal_op(ill0), .fault(flt0));

   multicycle_control_fsm #(.MEM_TIMEOUT(3), .ENABLE_JAL(0), .TRAP_ILLEGAL(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .op(op_in[1]), .Zero(zero), .mem_ready(mr_in[1]),
      .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .ResultSrc(rs1),
      .ALUSrcA(a1), .ALUSrcB(b1), .ImmSrc(imm1), .ALUOp(aop1), .RegWrite(rw1),
      .illegal_op(ill1), .fault(flt1));

   assign out0 = {pcw0, adr0, mw0, irw0, rs0, a0, b0, imm0, aop0, rw0, ill0, flt0};
   assign out1 = {pcw1, adr1, mw1, irw1, rs1, a1, b1, imm1, aop1, rw1, ill1, flt1};

   function automatic string cur(int d);
      return seq[d][sidx[d]];
   endfunction

   task automatic load(int d, string s0, string s1 = "", string s2 = "", string s3 = "");
      seq[d][0] = s0; seq[d][1] = s1; seq[d][2] = s2; seq[d][3] = s3;
      slen[d] = (s1 == "") ? 1 : (s2 == "") ? 2 : (s3 == "") ? 3 : 4;
      sidx[d] = 0;
   endtask

   function automatic bit legal(int d, logic [6:0] o);
      return o == LW || o == SW || o == RT || o == IT || o == BQ || (o == JL && JEN[d] != 0);
   endfunction

   // Each instruction is the list of steps it walks through after FETCH.
   task automatic build(int d);
      logic [6:0] o = op_in[d];
      if (o == LW)                      load(d, "DECODE", "MEMADR", "MEMREAD", "MEMWB");
      else if (o == SW)                 load(d, "DECODE", "MEMADR", "MEMWRITE");
      else if (o == RT)                 load(d, "DECODE", "EXR", "ALUWB");
      else if (o == IT)                 load(d, "DECODE", "EXI", "ALUWB");
      else if (o == BQ)                 load(d, "DECODE", "BEQ");
      else if (o == JL && JEN[d] != 0)  load(d, "DECODE", "JAL", "ALUWB");
      else if (TRAP[d] != 0)            load(d, "DECODE", "FAULT");
      else                              load(d, "DECODE");
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         load(d, "FETCH");
         wcnt[d] = 0;
      end
   endtask

   task automatic model_step(int d);
      string s = cur(d);
      if (!rst_n) begin load(d, "FETCH"); wcnt[d] = 0; return; end
      if (s == "FAULT") return;
      if ((s == "FETCH" || s == "MEMREAD" || s == "MEMWRITE") && !mr_in[d]) begin
         if (TMO[d] != 0 && wcnt[d] == TMO[d]) begin load(d, "FAULT"); wcnt[d] = 0; end
         else wcnt[d]++;
         return;
      end
      wcnt[d] = 0;
      if (s == "FETCH") build(d);
      else begin
         sidx[d]++;
         if (sidx[d] == slen[d]) load(d, "FETCH");
      end
   endtask

   function automatic logic [17:0] model_out(int d);
      logic pcw, adr, mw, irw, rw, ill, flt;
      logic [1:0] rs, a, b, aop;
      logic [2:0] imm;
      logic [6:0] o = op_in[d];
      string s = rst_n ? cur(d) : "FETCH";
      {pcw, adr, mw, irw, rw, ill, flt} = '0;
      {rs, a, b, aop, imm} = '0;
      if (s == "FETCH") begin rs = 2'b10; b = 2'b10; irw = mr_in[d]; pcw = mr_in[d]; end
      else if (s == "DECODE") begin
         a = 2'b01; b = 2'b01;
         imm = (o == BQ) ? 3'b010 : (o == JL) ? 3'b011 : 3'b000;
         ill = !legal(d, o);
      end
      else if (s == "MEMADR") begin a = 2'b10; b = 2'b01; imm = (o == SW) ? 3'b001 : 3'b000; end
      else if (s == "MEMREAD") adr = 1'b1;
      else if (s == "MEMWB") begin rs = 2'b01; rw = 1'b1; end
      else if (s == "MEMWRITE") begin adr = 1'b1; mw = 1'b1; end
      else if (s == "EXR") begin a = 2'b10; aop = 2'b10; end
      else if (s == "EXI") begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      else if (s == "ALUWB") rw = 1'b1;
      else if (s == "BEQ") begin a = 2'b10; aop = 2'b01; pcw = zero; end
      else if (s == "JAL") begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      else if (s == "FAULT") flt = 1'b1;
      if (!rst_n) {pcw, mw, irw, rw, ill, flt} = '0;
      return {pcw, adr, mw, irw, rs, a, b, imm, aop, rw, ill, flt};
   endfunction

   task automatic settle();
      #1;
      exp0 = model_out(0);
      exp1 = model_out(1);
   endtask

   task automatic advance();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      mr_in[0] = 1'b1; mr_in[1] = 1'b1; op_in[0] = RT; op_in[1] = RT;
      rst_n = 1'b0; model_reset();
      @(negedge clk); settle();
      checks++;
      if (out0 !== exp0) begin failures++; $display("FAIL reset_dut0 got=%b exp=%b", out0, exp0); end
      checks++;
      if (out1 !== exp1) begin failures++; $display("FAIL reset_dut1 got=%b exp=%b", out1, exp1); end
      checks++;
      if (irw0 !== 1'b0 || rs0 !== 2'b10) begin
         failures++; $display("FAIL reset_strobe got irw=%b rs=%b exp irw=0 rs=10", irw0, rs0);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      op_in[0] = RT; op_in[1] = IT; mr_in[0] = 1'b1; mr_in[1] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         settle();
         checks += 2;
         if (out0 !== exp0) begin failures++; $display("FAIL rtype_dut0 cyc=%0d got=%b exp=%b", c, out0, exp0); end
         if (out1 !== exp1) begin failures++; $display("FAIL itype_dut1 cyc=%0d got=%b exp=%b", c, out1, exp1); end
         if (c == 2 || c == 3) begin
            checks++;
            if (aop0 !== (c == 2 ? 2'b10 : 2'b00) || rw0 !== (c == 3)) begin
               failures++; $display("FAIL rtype_phase cyc=%0d got aop=%b rw=%b", c, aop0, rw0);
            end
         end
         advance();
      end
   endtask

   task automatic test_beq();
      op_in[0] = BQ; op_in[1] = JL; mr_in[0] = 1'b1; mr_in[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         zero = (c < 3);
         settle();
         checks += 2;
         if (out0 !== exp0) begin failures++; $display("FAIL beq_dut0 cyc=%0d got=%b exp=%b", c, out0, exp0); end
         if (out1 !== exp1) begin failures++; $display("FAIL jal_off_dut1 cyc=%0d got=%b exp=%b", c, out1, exp1); end
         if (c % 3 == 2) begin
            checks++;
            if (pcw0 !== zero) begin failures++; $display("FAIL beq_pcwrite got=%b exp=%b", pcw0, zero); end
         end
         advance();
      end
   endtask

   task automatic test_lw_stall();
      int stall[2] = '{0, 0};
      int rd_cycles = 0;
      op_in[0] = LW; op_in[1] = LW;
      for (int c = 0; c < 8; c++) begin
         for (int d = 0; d < 2; d++) begin
            mr_in[d] = !(cur(d) == "MEMREAD" && stall[d] < 3);
            if (!mr_in[d]) stall[d]++;
         end
         settle();
         if (adr0 === 1'b1) rd_cycles++;
         checks += 2;
         if (out0 !== exp0) begin failures++; $display("FAIL lw_dut0 cyc=%0d got=%b exp=%b", c, out0, exp0); end
         if (out1 !== exp1) begin failures++; $display("FAIL lw_dut1 cyc=%0d got=%b exp=%b", c, out1, exp1); end
         advance();
      end
      checks++;
      if (rd_cycles != 4) begin failures++; $display("FAIL lw_hold got=%0d exp=4", rd_cycles); end
   endtask

   task automatic test_sw_timeout();
      int mw_cnt[2] = '{0, 0};
      op_in[0] = SW; op_in[1] = SW;
      for (int c = 0; c < 24; c++) begin
         for (int d = 0; d < 2; d++) mr_in[d] = (cur(d) == "FETCH");
         settle();
         mw_cnt[0] += mw0; mw_cnt[1] += mw1;
         checks += 2;
         if (out0 !== exp0) begin failures++; $display("FAIL sw_dut0 cyc=%0d got=%b exp=%b", c, out0, exp0); end
         if (out1 !== exp1) begin failures++; $display("FAIL sw_dut1 cyc=%0d got=%b exp=%b", c, out1, exp1); end
         advance();
      end
      checks += 3;
      if (mw_cnt[0] != 16) begin failures++; $display("FAIL sw_hold16 got=%0d exp=16", mw_cnt[0]); end
      if (mw_cnt[1] != 4) begin failures++; $display("FAIL sw_hold4 got=%0d exp=4", mw_cnt[1]); end
      if (flt0 !== 1'b1 || flt1 !== 1'b1) begin
         failures++; $display("FAIL sw_fault got=%b%b exp=11", flt0, flt1);
      end
      do_reset();
   endtask

   task automatic test_illegal();
      op_in[0] = BAD; op_in[1] = BAD; mr_in[0] = 1'b1; mr_in[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         settle();
         checks += 2;
         if (out0 !== exp0) begin failures++; $display("FAIL illegal_dut0 cyc=%0d got=%b exp=%b", c, out0, exp0); end
         if (out1 !== exp1) begin failures++; $display("FAIL illegal_dut1 cyc=%0d got=%b exp=%b", c, out1, exp1); end
         if (c == 1) begin
            checks++;
            if (ill0 !== 1'b1 || ill1 !== 1'b1) begin failures++; $display("FAIL illegal_pulse got=%b%b exp=11", ill0, ill1); end
         end
         if (c == 2) begin
            checks++;
            if (flt0 !== 1'b1 || irw1 !== 1'b1) begin
               failures++; $display("FAIL illegal_next got fault0=%b irw1=%b exp 1 1", flt0, irw1);
            end
         end
         advance();
      end
      do_reset();
   endtask

   task automatic test_reset_mid_write();
      int inw = 0;
      op_in[0] = SW; op_in[1] = SW;
      for (int c = 0; c < 12 && inw < 2; c++) begin
         for (int d = 0; d < 2; d++) mr_in[d] = (cur(d) == "FETCH");
         settle();
         if (cur(0) == "MEMWRITE") inw++;
         advance();
      end
      settle();
      checks++;
      if (mw0 !== 1'b1) begin failures++; $display("FAIL midw_pre got=%b exp=1", mw0); end
      #2 rst_n = 1'b0;
      model_reset();
      settle();
      checks++;
      if (mw0 !== 1'b0 || out0 !== exp0) begin failures++; $display("FAIL midw_abort got=%b exp=%b", out0, exp0); end
      advance();
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         mr_in[0] = c[0]; mr_in[1] = c[0];
         settle();
         checks++;
         if (irw0 !== mr_in[0] || out0 !== exp0) begin
            failures++; $display("FAIL midw_fetch cyc=%0d got=%b exp=%b", c, out0, exp0);
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic [6:0] ops[8] = '{LW, SW, RT, IT, BQ, JL, BAD, 7'h00};
      int stuck = 0;
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (cur(d) == "FETCH") begin
               op_in[d] = ops[$urandom_range(0, 7)];
               if (op_in[d] == 7'h00) op_in[d] = 7'($urandom);
            end
            mr_in[d] = ($urandom_range(0, 3) != 0);
         end
         zero = $urandom_range(0, 1);
         settle();
         checks += 2;
         if (out0 !== exp0) begin failures++; $display("FAIL rand_dut0 cyc=%0d op=%b got=%b exp=%b", c, op_in[0], out0, exp0); end
         if (out1 !== exp1) begin failures++; $display("FAIL rand_dut1 cyc=%0d op=%b got=%b exp=%b", c, op_in[1], out1, exp1); end
         stuck = (cur(0) == "FAULT" || cur(1) == "FAULT") ? stuck + 1 : 0;
         if (stuck > 2) begin
            advance();
            do_reset();
            stuck = 0;
         end else advance();
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_beq();
      test_lw_stall();
      test_sw_timeout();
      test_illegal();
      test_reset_mid_write();
      do_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
